// File: rtl/inst_encoder_pkg.sv
// Shared definitions for the instruction encoder: opcodes, field layout, format encoding.
// Also holds the packing helper and the legal-opcode predicate used by INST_ENCODER_OPCODE_CHECK_EN.
package enc_pkg;

  localparam int WORD_W    = 32;
  localparam int OPCODE_W  = 6;
  localparam int REG_W     = 5;
  localparam int SHAMT_W   = 5;
  localparam int FUNC_W    = 6;
  localparam int IMM_W     = 16;

  localparam int OPCODE_LSB = 26;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNC_LSB   = 0;
  localparam int IMM_LSB    = 0;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;

  typedef enum logic {
    FMT_R = 1'b0,
    FMT_I = 1'b1
  } fmt_e;

  function automatic logic [WORD_W-1:0] pack_word(
    input fmt_e                fmt,
    input logic [OPCODE_W-1:0] opcode,
    input logic [REG_W-1:0]    rs,
    input logic [REG_W-1:0]    rt,
    input logic [REG_W-1:0]    rd,
    input logic [SHAMT_W-1:0]  shamt,
    input logic [FUNC_W-1:0]   func,
    input logic [IMM_W-1:0]    imm
  );
    logic [WORD_W-1:0] w;
    w = '0;
    w[OPCODE_LSB +: OPCODE_W] = opcode;
    w[RS_LSB     +: REG_W]    = rs;
    w[RT_LSB     +: REG_W]    = rt;
    if (fmt == FMT_I) begin
      w[IMM_LSB +: IMM_W] = imm;
    end else begin
      w[RD_LSB    +: REG_W]   = rd;
      w[SHAMT_LSB +: SHAMT_W] = shamt;
      w[FUNC_LSB  +: FUNC_W]  = func;
    end
    return w;
  endfunction

  function automatic logic opcode_legal(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW: return 1'b1;
      default:                                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Field-tuple input handshake and instruction-memory write port of the encoder.
// slave: the encoder; master: whoever drives tuples and models the memory.
interface inst_encoder_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // valid/ready: a transfer happens on a rising edge where both are high;
  // the producer holds its payload stable while valid && !ready.
  logic          in_valid;
  logic          in_ready;
  logic          fmt;
  logic [5:0]    opcode;
  logic [4:0]    rs;
  logic [4:0]    rt;
  logic [4:0]    rd;
  logic [4:0]    shamt;
  logic [5:0]    func;
  logic [15:0]   imm;
  logic          addr_load;
  logic [31:0]   base_addr;
  logic          mem_wr_en;
  logic          mem_ready;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wr_data;
  logic [CW-1:0] count;
  logic          err;

  modport slave (
    input  in_valid, fmt, opcode, rs, rt, rd, shamt, func, imm,
    input  addr_load, base_addr, mem_ready,
    output in_ready, mem_wr_en, mem_addr, mem_wr_data, count, err
  );

  modport master (
    output in_valid, fmt, opcode, rs, rt, rd, shamt, func, imm,
    output addr_load, base_addr, mem_ready,
    input  in_ready, mem_wr_en, mem_addr, mem_wr_data, count, err
  );

endinterface

// File: rtl/inst_encoder_fifo.sv
// inst_fifo: power-of-two circular buffer of packed instruction words.
// rd_data_o always shows the head entry; storage is cleared on reset so the head reads 0.
module inst_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 32,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // Guarded so a misbehaving caller can never overrun or underrun the pointers.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
    else if (pop_ok && !push_ok) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok) mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/inst_encoder.sv
// Packs R/I-type field tuples into 32-bit words, buffers them and streams them to instruction memory.
// Optional INST_ENCODER_OPCODE_CHECK_EN drops illegal opcodes and raises a sticky err.
module inst_encoder
  import enc_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_STEP  = 4
) (
  input logic           clk,
  input logic           rst_n,
  inst_encoder_if.slave bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [WORD_W-1:0] packed_word;
  logic [WORD_W-1:0] head_word;
  logic [31:0]       addr_q, addr_d;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic              in_ready, mem_wr_en;
  logic              accept, enq, out_xfer;

  assign in_ready  = !fifo_full;
  assign mem_wr_en = !fifo_empty;
  assign accept    = bus.in_valid && in_ready;
  assign out_xfer  = mem_wr_en && bus.mem_ready;

  assign packed_word = pack_word(fmt_e'(bus.fmt), bus.opcode, bus.rs, bus.rt,
                                 bus.rd, bus.shamt, bus.func, bus.imm);

`ifdef INST_ENCODER_OPCODE_CHECK_EN
  logic err_q, err_d;

  // Illegal opcodes still complete the handshake; they are just never stored.
  assign enq = accept && opcode_legal(bus.opcode);

  always_comb begin
    err_d = err_q;
    if (accept && !opcode_legal(bus.opcode)) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign bus.err = err_q;
`else
  assign enq     = accept;
  assign bus.err = 1'b0;
`endif

  // A load beats the post-transfer increment; the word leaving this cycle keeps the old address.
  always_comb begin
    addr_d = addr_q;
    if (bus.addr_load)  addr_d = bus.base_addr;
    else if (out_xfer)  addr_d = addr_q + 32'(ADDR_STEP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) addr_q <= '0;
    else        addr_q <= addr_d;
  end

  inst_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (enq),
    .wr_data_i (packed_word),
    .pop_i     (out_xfer),
    .rd_data_o (head_word),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  assign bus.in_ready    = in_ready;
  assign bus.mem_wr_en   = mem_wr_en;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wr_data = head_word;
  assign bus.count       = fifo_count;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed + lightly randomised bench for inst_encoder with a data scoreboard and an address model.
// Build with +define+INST_ENCODER_OPCODE_CHECK_EN to exercise the opcode filter.
module tb_inst_encoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  inst_encoder_if #(.FIFO_DEPTH(4)) bus ();

  inst_encoder #(
    .FIFO_DEPTH (4),
    .ADDR_STEP  (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_addr = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard and address model: a transfer seen at the negedge completes on the next posedge.
  always @(negedge clk) begin
    if (!rst_n) begin
      model_addr = '0;
    end else if (bus.mem_wr_en && bus.mem_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", bus.mem_wr_data, 32'hxxxxxxxx);
      end else begin
        chk("wr_data", bus.mem_wr_data, exp_q.pop_front());
        chk("wr_addr", bus.mem_addr, model_addr);
      end
      model_addr = bus.addr_load ? bus.base_addr : model_addr + 32'd4;
    end else if (bus.addr_load) begin
      model_addr = bus.base_addr;
    end
  end

  function automatic logic [31:0] ref_pack(input logic f, input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn, input logic [15:0] imm);
    return f ? {op, rs, rt, imm} : {op, rs, rt, rd, sh, fn};
  endfunction

  task automatic drive_tuple(input logic f, input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                             input logic [15:0] imm);
    bus.fmt = f; bus.opcode = op; bus.rs = rs; bus.rt = rt;
    bus.rd = rd; bus.shamt = sh; bus.func = fn; bus.imm = imm;
    bus.in_valid = 1'b1;
  endtask

  task automatic wait_accept();
    bit got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin got = 1'b1; break; end
    end
    chk("accept_timeout", 32'(got), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send(input logic f, input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                      input logic [15:0] imm, input logic [31:0] exp_word, input bit enq);
    drive_tuple(f, op, rs, rt, rd, sh, fn, imm);
    if (enq) exp_q.push_back(exp_word);
    wait_accept();
  endtask

  task automatic load_addr(input logic [31:0] b);
    bus.base_addr = b; bus.addr_load = 1'b1;
    @(posedge clk); #1;
    bus.addr_load = 1'b0;
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.count == '0) begin done = 1'b1; break; end
    end
    chk("drain_timeout", 32'(done), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0]  legal_ops [6];
    logic [31:0] held_data, held_addr;
    legal_ops = '{6'h00, 6'h04, 6'h05, 6'h08, 6'h23, 6'h2B};

    bus.in_valid = 0; bus.fmt = 0; bus.opcode = 0; bus.rs = 0; bus.rt = 0; bus.rd = 0;
    bus.shamt = 0; bus.func = 0; bus.imm = 0; bus.addr_load = 0; bus.base_addr = 0; bus.mem_ready = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_wr_en", 32'(bus.mem_wr_en), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_addr", bus.mem_addr, 32'd0);
    chk("rst_data", bus.mem_wr_data, 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    @(posedge clk); #1;

    // R-type vector, latency one cycle from empty
    load_addr(32'h100);
    bus.mem_ready = 1'b1;
    send(1'b0, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 32'h00221820, 1'b1);
    chk("lat_wr_en", 32'(bus.mem_wr_en), 32'd1);
    chk("lat_data", bus.mem_wr_data, 32'h00221820);
    chk("lat_addr", bus.mem_addr, 32'h100);
    wait_drain();

    // I-type vectors
    load_addr(32'h100);
    send(1'b1, 6'h23, 5'd4, 5'd5, 5'd31, 5'd31, 6'h3F, 16'h0008, 32'h8C850008, 1'b1);
    send(1'b1, 6'h2B, 5'd0, 5'd2, 5'd0, 5'd0, 6'h00, 16'h0004, 32'hAC020004, 1'b1);
    wait_drain();
    chk("itype_end_addr", bus.mem_addr, 32'h108);

    // Backpressure: four fill the buffer, fifth waits
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [4:0] a, b, c;
      a = 5'($urandom_range(0, 31)); b = 5'($urandom_range(0, 31)); c = 5'($urandom_range(0, 31));
      send(1'b0, 6'h00, a, b, c, 5'd0, 6'h22, 16'h0, ref_pack(1'b0, 6'h00, a, b, c, 5'd0, 6'h22, 16'h0), 1'b1);
    end
    drive_tuple(1'b1, 6'h08, 5'd7, 5'd8, 5'd0, 5'd0, 6'h0, 16'hBEEF);
    exp_q.push_back(32'h20E8BEEF);
    @(negedge clk);
    chk("full_count", 32'(bus.count), 32'd4);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    held_data = bus.mem_wr_data; held_addr = bus.mem_addr;
    repeat (2) @(negedge clk);
    chk("stall_data_stable", bus.mem_wr_data, held_data);
    chk("stall_addr_stable", bus.mem_addr, held_addr);
    @(posedge clk); #1;
    bus.mem_ready = 1'b1;
    wait_accept();
    wait_drain();

    // Address wrap
    bus.mem_ready = 1'b0;
    load_addr(32'hFFFFFFFC);
    send(1'b1, 6'h04, 5'd1, 5'd1, 5'd0, 5'd0, 6'h0, 16'hFFFF, 32'h1021FFFF, 1'b1);
    send(1'b1, 6'h05, 5'd2, 5'd3, 5'd0, 5'd0, 6'h0, 16'h0010, 32'h14430010, 1'b1);
    chk("wrap_first_addr", bus.mem_addr, 32'hFFFFFFFC);
    bus.mem_ready = 1'b1;
    wait_drain();
    chk("wrap_end_addr", bus.mem_addr, 32'h00000004);

    // Load coincident with a transfer: load wins, departing word keeps old address
    bus.mem_ready = 1'b0;
    load_addr(32'h200);
    for (int i = 0; i < 3; i++)
      send(1'b1, 6'h23, 5'(i), 5'(i + 1), 5'd0, 5'd0, 6'h0, 16'(i * 4),
           ref_pack(1'b1, 6'h23, 5'(i), 5'(i + 1), 5'd0, 5'd0, 6'h0, 16'(i * 4)), 1'b1);
    bus.mem_ready = 1'b1;
    load_addr(32'h300);
    wait_drain();
    chk("coinc_end_addr", bus.mem_addr, 32'h308);

    // Random legal tuples streamed back to back
    for (int i = 0; i < 12; i++) begin
      logic [5:0] op; logic f; logic [4:0] a, b, c, s; logic [5:0] fn; logic [15:0] im;
      op = legal_ops[$urandom_range(0, 5)];
      f = (op != 6'h00);
      a = 5'($urandom); b = 5'($urandom); c = 5'($urandom); s = 5'($urandom);
      fn = 6'($urandom); im = 16'($urandom);
      send(f, op, a, b, c, s, fn, im, ref_pack(f, op, a, b, c, s, fn, im), 1'b1);
    end
    wait_drain();

    // Opcode 0x3F
`ifdef INST_ENCODER_OPCODE_CHECK_EN
    send(1'b0, 6'h3F, 5'd1, 5'd2, 5'd3, 5'd4, 6'h05, 16'h0, 32'h0, 1'b0);
    chk("illegal_count", 32'(bus.count), 32'd0);
    chk("illegal_err", 32'(bus.err), 32'd1);
    repeat (3) @(posedge clk);
    #1 chk("illegal_err_sticky", 32'(bus.err), 32'd1);
`else
    send(1'b0, 6'h3F, 5'd1, 5'd2, 5'd3, 5'd4, 6'h05, 16'h0, 32'hFC221905, 1'b1);
    wait_drain();
    chk("no_check_err", 32'(bus.err), 32'd0);
`endif

    // Reset mid-operation discards buffered words
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(1'b1, 6'h08, 5'd9, 5'd9, 5'd0, 5'd0, 6'h0, 16'(i), 32'h0, 1'b0);
    chk("pre_rst_count", 32'(bus.count), 32'd3);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mid_rst_count", 32'(bus.count), 32'd0);
    chk("mid_rst_wr_en", 32'(bus.mem_wr_en), 32'd0);
    chk("mid_rst_addr", bus.mem_addr, 32'd0);
    chk("mid_rst_err", 32'(bus.err), 32'd0);
    chk("mid_rst_data", bus.mem_wr_data, 32'd0);
    exp_q.delete();

    repeat (2) @(posedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, number of packed words buffered (power of two, >=2).
REQ-002 Parameter: ADDR_STEP, 4, byte increment of the write address per stored word.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port: in_valid  input  1  field tuple presented.
REQ-006 Port: in_ready  output  1  encoder can accept a tuple.
REQ-007 Port: fmt  input  1  0 = R-type, 1 = I-type.
REQ-008 Ports: opcode  input  6; rs, rt, rd, shamt  input  5 each; func  input  6; imm  input  16.
REQ-009 Port: addr_load  input  1  pulse: load write address from base_addr.
REQ-010 Port: base_addr  input  32  start byte address for instruction memory.
REQ-011 Port: mem_wr_en  output  1  word valid toward instruction memory.
REQ-012 Port: mem_ready  input  1  instruction memory accepts the word.
REQ-013 Port: mem_addr  output  32  byte address of the current word.
REQ-014 Port: mem_wr_data  output  32  packed instruction word.
REQ-015 Port: count  output  log2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-016 Port: err  output  1  sticky illegal-opcode flag.

Function
REQ-017 R-type packing SHALL be {opcode, rs, rt, rd, shamt, func}; I-type packing SHALL be {opcode, rs, rt, imm}; rd/shamt/func ignored for I-type.
REQ-018 Input transfer SHALL occur when in_valid && in_ready; in_ready SHALL equal (count != FIFO_DEPTH), from registered state only.
REQ-019 An accepted word SHALL appear at mem_wr_data no earlier than the next cycle (latency 1 when FIFO empty).
REQ-020 mem_wr_en SHALL equal (count != 0); output transfer SHALL occur when mem_wr_en && mem_ready.
REQ-021 mem_wr_data and mem_addr SHALL hold stable while mem_wr_en && !mem_ready.
REQ-022 Each output transfer SHALL advance mem_addr by ADDR_STEP, modulo 2^32 (0xFFFFFFFC + 4 = 0x00000000).
REQ-023 addr_load SHALL set mem_addr = base_addr next cycle; if coincident with an output transfer, the transferred word uses the old address and load wins over increment.
REQ-024 Simultaneous input and output transfer SHALL leave count unchanged and preserve FIFO order.
REQ-025 Words SHALL leave in the order accepted; no word dropped or duplicated.

Reset
REQ-026 While rst_n is low at a clock edge: count=0, mem_wr_en=0, in_ready=1 after release, mem_addr=0, mem_wr_data=0, err=0, FIFO pointers=0.
REQ-027 Reset mid-operation SHALL discard all buffered words; no memory write occurs in the reset cycle.

Configuration
REQ-028 Macro INST_ENCODER_OPCODE_CHECK_EN, when defined, SHALL restrict accepted opcodes to 0x00, 0x04, 0x05, 0x08, 0x23, 0x2B; other opcodes complete the handshake, are not enqueued, and set err.
REQ-029 Without INST_ENCODER_OPCODE_CHECK_EN, every opcode SHALL be enqueued and err SHALL be tied 0.

Structure
REQ-030 Shared package enc_pkg SHALL hold opcode constants (OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW), field widths/bit positions, and the fmt encoding.
REQ-031 Buffering SHALL be a sub-module inst_fifo (push/pop/full/empty/count, depth FIFO_DEPTH); packing and address counter stay in inst_encoder.

Verification
REQ-032 R-type rs=1 rt=2 rd=3 shamt=0 func=0x20, addr_load base 0x100 -> mem_wr_data 0x00221820 at mem_addr 0x100.
REQ-033 I-type opcode 0x23 rs=4 rt=5 imm=8, then opcode 0x2B rs=0 rt=2 imm=4 -> 0x8C850008 at 0x100, 0xAC020004 at 0x104.
REQ-034 mem_ready=0, 5 tuples offered -> 4 accepted, count=4, in_ready=0; mem_ready=1 -> 4 words in order, then 5th accepted.
REQ-035 base_addr 0xFFFFFFFC, 2 words -> writes at 0xFFFFFFFC then 0x00000000.
REQ-036 count=3, rst_n low 1 cycle -> count=0, mem_wr_en=0, mem_addr=0, err=0 next cycle.
REQ-037 Opcode 0x3F with INST_ENCODER_OPCODE_CHECK_EN -> count unchanged, err=1 until reset; without macro -> word 0xFC000000 | fields written.
